// File: rtl/fir_ram_chan_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fir_ram_chan_sched
//
// Round-robin scheduler that time-shares one FIR engine among CHANNELS sample
// streams. Per-channel sample-valid pulses are latched as pending requests.
// One engine computation is started at a time, the engine result is captured
// a fixed CALC_CYCLES after the start, and it is returned tagged with the
// channel that produced it.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   ch_val_i     per-channel "new sample stored" pulses
//   fir_start_o  one-cycle start pulse to the engine
//   fir_chan_o   channel being computed (steers engine RAM/coef bank select)
//   fir_data_i   engine result, valid CALC_CYCLES after fir_start_o
//   res_val_o    one-cycle result strobe
//   res_chan_o   channel of the current result
//   res_data_o   captured result, held until the next capture
//   busy_o       high whenever the scheduler is not idle
//   err_clr_i    clears all overrun flags
//   err_ovr_o    sticky per-channel overrun flags
// -----------------------------------------------------------------------------
module fir_ram_chan_sched #(
    parameter int CHANNELS    = 4,
    parameter int OUT_WIDTH   = 16,
    parameter int CALC_CYCLES = 72,
    parameter int CH_WIDTH    = $clog2(CHANNELS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [CHANNELS-1:0]         ch_val_i,
    output logic                        fir_start_o,
    output logic [CH_WIDTH-1:0]         fir_chan_o,
    input  logic signed [OUT_WIDTH-1:0] fir_data_i,
    output logic                        res_val_o,
    output logic [CH_WIDTH-1:0]         res_chan_o,
    output logic signed [OUT_WIDTH-1:0] res_data_o,
    output logic                        busy_o,
    input  logic                        err_clr_i,
    output logic [CHANNELS-1:0]         err_ovr_o
);

    // Counter only ever holds values up to CALC_CYCLES-2.
    localparam int CNT_WIDTH = (CALC_CYCLES > 2) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(CALC_CYCLES - 2);
    localparam logic [CH_WIDTH-1:0]  LAST_RST = CH_WIDTH'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [CHANNELS-1:0]           pending_q, pending_d;
    logic [CHANNELS-1:0]           err_q, err_d;
    logic [CH_WIDTH-1:0]           sel_q, sel_d;
    logic [CH_WIDTH-1:0]           last_q, last_d;
    logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic                          fir_start_q, fir_start_d;
    logic                          res_val_q, res_val_d;
    logic [CH_WIDTH-1:0]           res_chan_q, res_chan_d;
    logic signed [OUT_WIDTH-1:0]   res_data_q, res_data_d;
    logic                          busy_q, busy_d;

    logic [CHANNELS-1:0]           clr_vec;
    logic [CH_WIDTH-1:0]           rr_pick;
    logic [CH_WIDTH-1:0]           rr_cand;

    // A channel's pending bit is consumed in the START cycle that grants it.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign clr_vec[gi] = (state_q == ST_START) && (sel_q == CH_WIDTH'(gi));
        end
    endgenerate

    // Round-robin pick: first pending channel searching upward from last+1.
    // Iterating from the farthest offset down to the nearest lets the
    // nearest pending channel overwrite the others without an early exit.
    always_comb begin
        rr_pick = last_q;
        rr_cand = last_q;
        for (int i = CHANNELS; i >= 1; i--) begin
            rr_cand = CH_WIDTH'((int'(last_q) + i) % CHANNELS);
            if (pending_q[rr_cand]) begin
                rr_pick = rr_cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        fir_start_d = 1'b0;
        res_val_d   = 1'b0;
        res_chan_d  = res_chan_q;
        res_data_d  = res_data_q;

        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    sel_d       = rr_pick;
                    fir_start_d = 1'b1;   // registered so it is high exactly in START
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                last_d  = sel_q;
                cnt_d   = CNT_LOAD;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                res_data_d = fir_data_i;
                res_chan_d = sel_q;
                res_val_d  = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        // New request wins over the grant clear, so a sample arriving in its
        // own START cycle stays queued and is not an overrun.
        pending_d = (pending_q & ~clr_vec) | ch_val_i;
        err_d     = (err_clr_i ? '0 : err_q) | (ch_val_i & pending_q & ~clr_vec);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            err_q       <= '0;
            sel_q       <= '0;
            last_q      <= LAST_RST;
            cnt_q       <= '0;
            fir_start_q <= 1'b0;
            res_val_q   <= 1'b0;
            res_chan_q  <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            fir_start_q <= fir_start_d;
            res_val_q   <= res_val_d;
            res_chan_q  <= res_chan_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
        end
    end

    assign fir_start_o = fir_start_q;
    assign fir_chan_o  = sel_q;
    assign res_val_o   = res_val_q;
    assign res_chan_o  = res_chan_q;
    assign res_data_o  = res_data_q;
    assign busy_o      = busy_q;
    assign err_ovr_o   = err_q;

endmodule

// File: tb/tb_fir_ram_chan_sched.sv
`timescale 1ns/1ps
module tb_fir_ram_chan_sched;

    localparam int CH  = 4;
    localparam int CC  = 10;
    localparam int PER = CC + 2;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic [CH-1:0]      ch_val_i = '0;
    logic               fir_start_o;
    logic [1:0]         fir_chan_o;
    logic signed [15:0] fir_data_i = 16'hDEAD;
    logic               res_val_o;
    logic [1:0]         res_chan_o;
    logic signed [15:0] res_data_o;
    logic               busy_o;
    logic               err_clr_i = 1'b0;
    logic [CH-1:0]      err_ovr_o;

    fir_ram_chan_sched #(.CHANNELS(CH), .OUT_WIDTH(16), .CALC_CYCLES(CC)) dut (
        .clk_i(clk), .rst_i(rst_i), .ch_val_i(ch_val_i),
        .fir_start_o(fir_start_o), .fir_chan_o(fir_chan_o), .fir_data_i(fir_data_i),
        .res_val_o(res_val_o), .res_chan_o(res_chan_o), .res_data_o(res_data_o),
        .busy_o(busy_o), .err_clr_i(err_clr_i), .err_ovr_o(err_ovr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] ch;
        logic [15:0] val;
    } ev_t;

    ev_t starts[$];
    ev_t results[$];
    int  cyc = 0;
    int  n_starts = 0;
    int  stub_due = -1;
    logic [15:0] stub_val = '0;
    int  vec_cnt = 0;
    int  err_cnt = 0;

    // Engine stub plus event monitor; runs 1 ns after every rising edge.
    initial begin
        forever begin
            ev_t e;
            @(posedge clk);
            #1;
            cyc++;
            if (rst_i) stub_due = -1;
            if (fir_start_o) begin
                e.cyc = cyc; e.ch = fir_chan_o;
                e.val = 16'h1234 ^ 16'(n_starts * 32'h2211);
                starts.push_back(e);
                stub_due = cyc + CC;
                stub_val = e.val;
                n_starts++;
            end
            if (res_val_o) begin
                e.cyc = cyc; e.ch = res_chan_o; e.val = res_data_o;
                results.push_back(e);
                $display("result: ch=%0d data=%h cyc=%0d", res_chan_o, res_data_o, cyc);
            end
            fir_data_i = (cyc == stub_due) ? stub_val : 16'hDEAD;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse_ch(input logic [CH-1:0] v);
        ch_val_i = v;
        @(posedge clk); #2;
        ch_val_i = '0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int k = 0;
        while (results.size() < n && k < budget) begin
            @(posedge clk); #2; k++;
        end
        chk("results_in_time", 32'(results.size() >= n), 32'd1);
    endtask

    task automatic wait_start();
        int k = 0;
        while (!fir_start_o && k < 20) begin
            @(posedge clk); #2; k++;
        end
        chk("start_seen", 32'(fir_start_o), 32'd1);
    endtask

    typedef struct {
        logic [3:0] req;
        int         n;
        logic [7:0] order;   // order[2*i +: 2] = channel of i-th grant
    } vec_t;

    vec_t tbl[6];

    initial begin
        int t0;
        tbl[0] = '{4'b1111, 4, 8'b11_10_01_00};  // last=3 after reset -> 0,1,2,3
        tbl[1] = '{4'b0001, 1, 8'b00_00_00_00};  // -> 0, last=0
        tbl[2] = '{4'b1001, 2, 8'b00_00_00_11};  // from 1 upward -> 3, then 0
        tbl[3] = '{4'b0100, 1, 8'b00_00_00_10};  // -> 2
        tbl[4] = '{4'b0110, 2, 8'b00_00_10_01};  // from 3 -> 1, then 2
        tbl[5] = '{4'b1010, 2, 8'b00_00_01_11};  // from 3 -> 3, then 1

        // Reset and idle
        repeat (3) @(posedge clk);
        #2 rst_i = 1'b0;
        idle(2);
        chk("rst_fir_start", 32'(fir_start_o), 0);
        chk("rst_fir_chan", 32'(fir_chan_o), 0);
        chk("rst_res_val", 32'(res_val_o), 0);
        chk("rst_res_chan", 32'(res_chan_o), 0);
        chk("rst_res_data", 32'(res_data_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_err", 32'(err_ovr_o), 0);
        starts.delete(); results.delete();
        idle(20);
        chk("idle_no_start", 32'(starts.size()), 0);
        chk("idle_busy", 32'(busy_o), 0);

        // Table-driven arbitration vectors
        for (int v = 0; v < 6; v++) begin
            starts.delete(); results.delete();
            t0 = cyc;
            pulse_ch(tbl[v].req);
            wait_results(tbl[v].n, tbl[v].n * PER + 20);
            idle(5);
            chk("n_starts", 32'(starts.size()), 32'(tbl[v].n));
            chk("n_results", 32'(results.size()), 32'(tbl[v].n));
            for (int i = 0; i < tbl[v].n; i++) begin
                if (i < starts.size() && i < results.size()) begin
                    chk("start_chan", 32'(starts[i].ch), 32'(tbl[v].order[2*i +: 2]));
                    chk("start_cyc", 32'(starts[i].cyc), 32'(t0 + 2 + PER * i));
                    chk("res_chan", 32'(results[i].ch), 32'(tbl[v].order[2*i +: 2]));
                    chk("res_cyc", 32'(results[i].cyc), 32'(starts[i].cyc + CC + 1));
                    chk("res_data", 32'(results[i].val), 32'(starts[i].val));
                end
            end
            chk("tbl_busy", 32'(busy_o), 0);
            chk("tbl_err", 32'(err_ovr_o), 0);
        end
        chk("hold_res_data", 32'(res_data_o), 32'(results[results.size()-1].val));

        // Overrun while channel 0 is busy, clear/overrun collision, then clear
        starts.delete(); results.delete();
        pulse_ch(4'b0001);
        idle(3);
        pulse_ch(4'b0010);
        chk("ovr_first_ok", 32'(err_ovr_o), 0);
        pulse_ch(4'b0010);
        chk("ovr_flag", 32'(err_ovr_o), 32'b0010);
        err_clr_i = 1'b1; ch_val_i = 4'b0010;
        @(posedge clk); #2;
        err_clr_i = 1'b0; ch_val_i = '0;
        chk("ovr_beats_clr", 32'(err_ovr_o), 32'b0010);
        wait_results(2, 3 * PER);
        idle(PER + 5);
        chk("ovr_n_starts", 32'(starts.size()), 2);
        if (starts.size() == 2) chk("ovr_second_ch", 32'(starts[1].ch), 1);
        err_clr_i = 1'b1;
        @(posedge clk); #2;
        err_clr_i = 1'b0;
        chk("err_clr", 32'(err_ovr_o), 0);

        // Request in channel 0's START cycle: no error, second computation
        starts.delete(); results.delete();
        pulse_ch(4'b0001);
        wait_start();
        pulse_ch(4'b0001);
        chk("coll_start_err", 32'(err_ovr_o), 0);
        wait_results(2, 3 * PER);
        idle(5);
        chk("coll_start_n", 32'(starts.size()), 2);
        if (starts.size() == 2) chk("coll_start_ch", 32'(starts[1].ch), 0);

        // Request in channel 0's first BUSY cycle: no error
        starts.delete(); results.delete();
        pulse_ch(4'b0001);
        wait_start();
        idle(1);
        pulse_ch(4'b0001);
        chk("coll_busy_err", 32'(err_ovr_o), 0);
        wait_results(2, 3 * PER);
        idle(5);
        chk("coll_busy_n", 32'(starts.size()), 2);

        // Reset mid-computation with two requests pending
        starts.delete(); results.delete();
        pulse_ch(4'b0111);
        idle(4);
        chk("mid_busy_before", 32'(busy_o), 1);
        rst_i = 1'b1;
        #1;
        chk("mid_async_busy", 32'(busy_o), 0);
        idle(2);
        rst_i = 1'b0;
        idle(3 * PER);
        chk("mid_no_result", 32'(results.size()), 0);
        chk("mid_one_start", 32'(starts.size()), 1);
        chk("mid_busy", 32'(busy_o), 0);
        chk("mid_res_data", 32'(res_data_o), 0);
        chk("mid_fir_chan", 32'(fir_chan_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_ram_chan_sched.md
# fir_ram_chan_sched

Round-robin scheduler that time-shares one `fir_ram_cpu` FIR engine among `CHANNELS` independent sample streams. It latches per-channel sample-valid requests, issues one start pulse per computation to the engine, and drives the channel index used to steer the engine's data-RAM and coefficient-bank selection. It captures the engine result after a fixed latency and returns it tagged with its channel. It sits between the per-channel sample writers and the shared FIR engine.

## Interface
- `CHANNELS`, 4: number of requesting channels; must be at least 2.
- `OUT_WIDTH`, 16: width of the engine result.
- `CALC_CYCLES`, 72: cycles from `fir_start_o` to a valid `fir_data_i`. The engine must be back in IDLE by then. Must be at least 2.
- `CH_WIDTH`, `$clog2(CHANNELS)`: channel index width. Derived; must not be overridden.
- `clk_i`, in, 1: system clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `ch_val_i`, in, CHANNELS: one-cycle pulse per channel, meaning a new sample is stored and ready for filtering.
- `fir_start_o`, out, 1: one-cycle start pulse to the engine's `data_val_i`.
- `fir_chan_o`, out, CH_WIDTH: channel currently being computed. Held stable from START through CAPTURE.
- `fir_data_i`, in, OUT_WIDTH (signed): engine result.
- `res_val_o`, out, 1: one-cycle result strobe.
- `res_chan_o`, out, CH_WIDTH: channel of the current result.
- `res_data_o`, out, OUT_WIDTH (signed): captured result.
- `busy_o`, out, 1: high in every state except IDLE.
- `err_clr_i`, in, 1: synchronous clear of `err_ovr_o`.
- `err_ovr_o`, out, CHANNELS: sticky per-channel overrun flags.

## Operation
- Each channel has a `pending[k]` bit.
  - `ch_val_i[k]` sets `pending[k]`.
  - The bit is cleared in the START cycle that grants channel k.
  - If set and clear occur in the same cycle, set wins, so the new sample stays queued.
- Overrun: if `ch_val_i[k]` arrives while `pending[k]` is 1 and k is not being cleared that cycle, `err_ovr_o[k]` is set. The request remains a single pending entry; samples are not counted.
- `err_clr_i` clears all `err_ovr_o` bits. If a clear and a new overrun occur in the same cycle, the new overrun wins.
- FSM states: IDLE, START, BUSY, CAPTURE.
  - IDLE: if any `pending` bit is set, register `sel`, the first pending channel searching from `last+1` modulo CHANNELS upward. Then go to START.
  - START: `fir_start_o`=1, `fir_chan_o`=`sel`, `last`<=`sel`, clear `pending[sel]`, load the down-counter with `CALC_CYCLES-2`. Go to BUSY.
  - BUSY: decrement the counter. At 0, go to CAPTURE. With `CALC_CYCLES`=2, BUSY lasts one cycle.
  - CAPTURE: register `fir_data_i` into `res_data_o` and `sel` into `res_chan_o`. Assert `res_val_o` on the next cycle. Go to IDLE.
- Arbitration is round-robin, so no channel waits for more than CHANNELS-1 other computations.
- `res_data_o` and `res_chan_o` hold their values until the next capture.
- An invalid state goes to IDLE.

## Timing
- Reset values: `fir_start_o`=0, `fir_chan_o`=0, `res_val_o`=0, `res_chan_o`=0, `res_data_o`=0, `busy_o`=0, `err_ovr_o`=0, `pending`=0, FSM=IDLE, `last`=CHANNELS-1 (so channel 0 wins first).
- Let the START cycle be S.
  - IDLE decision: S-1.
  - `fir_start_o` high: S only.
  - BUSY: S+1 through S+CALC_CYCLES-1.
  - CAPTURE: S+CALC_CYCLES, sampling `fir_data_i` on that edge.
  - `res_val_o` high: S+CALC_CYCLES+1, at which point the FSM is back in IDLE.
  - Next START at the earliest: S+CALC_CYCLES+2.
  - Throughput: one result per CALC_CYCLES+2 cycles.
- Request latency: `ch_val_i` at cycle t with the FSM in IDLE gives `pending` at t+1, IDLE decision at t+1, and START at t+2.
- A request arriving during BUSY or CAPTURE is queued and served after the current computation.
- Reset mid-computation: all state is dropped immediately, no result is issued, and pending requests are lost.
- `fir_start_o` is never asserted outside START. This guarantees the engine never sees a start while busy.

## Test plan
- Reset and idle: hold `rst_i`, release, leave `ch_val_i`=0 -> all outputs stay 0 and `busy_o`=0 indefinitely.
- Single request (CHANNELS=4, CALC_CYCLES=10): pulse `ch_val_i[2]` at t0 -> `fir_start_o` at t0+2 with `fir_chan_o`=2. With a stub returning 0x1234 at t0+12, `res_val_o` is asserted at t0+13 with `res_chan_o`=2 and `res_data_o`=0x1234.
- Round-robin: pulse `ch_val_i`=4'b1111 in one cycle -> START order 0,1,2,3, with starts spaced 12 cycles apart and four tagged results. Repeat with 4'b1001 after the last grant was 0 -> order 3, then 0.
- Overrun: pulse `ch_val_i[1]` twice while channel 0 is BUSY -> `err_ovr_o`=4'b0010 and channel 1 is computed exactly once. Pulse `err_clr_i` -> `err_ovr_o`=0.
- Set/clear collision: pulse `ch_val_i[0]` again in channel 0's START cycle -> no error flag and a second channel-0 computation follows. Pulse it in channel 0's BUSY cycle -> no error.
- Mid-run reset: assert `rst_i` during BUSY with 2 requests pending -> `res_val_o` is never asserted, and after release the block is idle with `pending`=0.
